// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: PC register, IF/ID register and RUN/HOLD/HALT fetch FSM.
// Optional feature macro: IFETCH_PERF_CNT_EN adds a saturating Fetch_Count output.
module instruction_fetch_controller #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_WORD = 16'hF000
) (
    input  logic        Clock,
    input  logic        Reset_n,
    output logic [15:0] Imem_Addr,
    input  logic [15:0] Imem_Data,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [15:0] Branch_Target,
    input  logic        Halt,
    output logic [15:0] Instr_Out,
    output logic [15:0] PC_Out,
    output logic        Instr_Valid,
`ifdef IFETCH_PERF_CNT_EN
    output logic [15:0] Fetch_Count,
`endif
    output logic [1:0]  Fetch_State
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        HALT = 2'b11
    } fetch_state_t;

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  instr_q, instr_d;
    logic [15:0]  pc_out_q, pc_out_d;
    logic         valid_q, valid_d;
    logic         fetch_en;

    // Priority inside the active states: branch, then halt, then stall, then fetch.
    // HALT ignores Halt and Stall, so only a branch (or reset) leaves it.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        fetch_en = 1'b0;
        if (state_q == IDLE) begin
            state_d = RUN;
        end else if (Branch_Taken) begin
            pc_d    = Branch_Target;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (state_q == HALT) begin
            state_d = HALT;
        end else if (Halt) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            state_d = HALT;
        end else if (Stall) begin
            state_d = HOLD;
        end else begin
            fetch_en = 1'b1;
            instr_d  = Imem_Data;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 16'd1;
            state_d  = RUN;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_WORD;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (fetch_en && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            fetch_count_q <= 16'h0000;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign Fetch_Count = fetch_count_q;
`else
    logic unused_fetch_en;
    assign unused_fetch_en = fetch_en;
`endif

    assign Imem_Addr   = pc_q;
    assign Instr_Out   = instr_q;
    assign PC_Out      = pc_out_q;
    assign Instr_Valid = valid_q;
    assign Fetch_State = state_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench for instruction_fetch_controller; ROM word at address a is 16'h0046 + a*16'h0041.
module tb_instruction_fetch_controller;

    logic        Clock;
    logic        Reset_n;
    logic [15:0] Imem_Addr;
    logic [15:0] Imem_Data;
    logic        Stall;
    logic        Branch_Taken;
    logic [15:0] Branch_Target;
    logic        Halt;
    logic [15:0] Instr_Out;
    logic [15:0] PC_Out;
    logic        Instr_Valid;
    logic [1:0]  Fetch_State;
`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] Fetch_Count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    instruction_fetch_controller dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .Imem_Addr    (Imem_Addr),
        .Imem_Data    (Imem_Data),
        .Stall        (Stall),
        .Branch_Taken (Branch_Taken),
        .Branch_Target(Branch_Target),
        .Halt         (Halt),
        .Instr_Out    (Instr_Out),
        .PC_Out       (PC_Out),
        .Instr_Valid  (Instr_Valid),
`ifdef IFETCH_PERF_CNT_EN
        .Fetch_Count  (Fetch_Count),
`endif
        .Fetch_State  (Fetch_State)
    );

    // Combinational ROM model
    assign Imem_Data = 16'h0046 + Imem_Addr * 16'h0041;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [15:0] addr, input logic [15:0] instr,
                             input logic [15:0] pco, input logic vld, input logic [1:0] st);
        check({tag, "_addr"}, Imem_Addr, addr);
        check({tag, "_instr"}, Instr_Out, instr);
        if (vld) check({tag, "_pcout"}, PC_Out, pco);
        check({tag, "_valid"}, {15'd0, Instr_Valid}, {15'd0, vld});
        check({tag, "_state"}, {14'd0, Fetch_State}, {14'd0, st});
    endtask

    initial begin
        Reset_n = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0; Branch_Target = 16'h0000; Halt = 1'b0;
        step(); step();
        check_out("rst", 16'h0000, 16'hF000, 16'h0000, 1'b0, 2'b00);
        check("rst_pcout", PC_Out, 16'h0000);

        // IDLE ignores controls
        Reset_n = 1'b1; Halt = 1'b1; Stall = 1'b1; Branch_Taken = 1'b1; Branch_Target = 16'h0077;
        step();
        check_out("idle", 16'h0000, 16'hF000, 16'h0000, 1'b0, 2'b01);
        Halt = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0;

        step(); check_out("run0", 16'h0001, 16'h0046, 16'h0000, 1'b1, 2'b01);
        step(); check_out("run1", 16'h0002, 16'h0087, 16'h0001, 1'b1, 2'b01);
        step(); check_out("run2", 16'h0003, 16'h00C8, 16'h0002, 1'b1, 2'b01);
        step(); step();
        check_out("run4", 16'h0005, 16'h014A, 16'h0004, 1'b1, 2'b01);

        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("stall", 16'h0005, 16'h014A, 16'h0004, 1'b1, 2'b10);
        end
        Stall = 1'b0;
        step(); check_out("unstall", 16'h0006, 16'h018B, 16'h0005, 1'b1, 2'b01);

        Stall = 1'b1; Branch_Taken = 1'b1; Branch_Target = 16'h000A;
        step(); check_out("br", 16'h000A, 16'hF000, 16'h0000, 1'b0, 2'b01);
        Stall = 1'b0; Branch_Taken = 1'b0;
        step(); check_out("br_tgt", 16'h000B, 16'h02D0, 16'h000A, 1'b1, 2'b01);
        step(); check_out("run11", 16'h000C, 16'h0311, 16'h000B, 1'b1, 2'b01);

        Halt = 1'b1;
        step(); check_out("halt", 16'h000C, 16'hF000, 16'h0000, 1'b0, 2'b11);
        for (int i = 0; i < 10; i++) begin
            Halt = 1'(i % 2);
            Stall = (i < 5);
            step();
            check_out("halted", 16'h000C, 16'hF000, 16'h0000, 1'b0, 2'b11);
        end
        Halt = 1'b0; Stall = 1'b0; Branch_Taken = 1'b1; Branch_Target = 16'h0000;
        step(); check_out("unhalt", 16'h0000, 16'hF000, 16'h0000, 1'b0, 2'b01);
        Branch_Taken = 1'b0;
        step(); check_out("restart", 16'h0001, 16'h0046, 16'h0000, 1'b1, 2'b01);

        Branch_Taken = 1'b1; Branch_Target = 16'hFFFF; Halt = 1'b1;
        step(); check_out("br_ffff", 16'hFFFF, 16'hF000, 16'h0000, 1'b0, 2'b01);
        Branch_Taken = 1'b0; Halt = 1'b0;
        step(); check_out("wrap", 16'h0000, 16'h0005, 16'hFFFF, 1'b1, 2'b01);

        Stall = 1'b1;
        step(); check_out("hold_pre_rst", 16'h0000, 16'h0005, 16'hFFFF, 1'b1, 2'b10);
        Reset_n = 1'b0; Branch_Taken = 1'b1; Branch_Target = 16'h0033;
        step();
        check_out("rst_mid", 16'h0000, 16'hF000, 16'h0000, 1'b0, 2'b00);
        check("rst_mid_pcout", PC_Out, 16'h0000);
`ifdef IFETCH_PERF_CNT_EN
        check("cnt_rst", Fetch_Count, 16'h0000);
`endif
        Reset_n = 1'b1; Branch_Taken = 1'b0; Stall = 1'b0;
        step(); check_out("idle2", 16'h0000, 16'hF000, 16'h0000, 1'b0, 2'b01);
        for (int i = 0; i < 5; i++) step();
        check_out("run5", 16'h0005, 16'h014A, 16'h0004, 1'b1, 2'b01);
        Stall = 1'b1;
        step(); step();
        Stall = 1'b0; Branch_Taken = 1'b1; Branch_Target = 16'h0020;
        step(); check_out("br2", 16'h0020, 16'hF000, 16'h0000, 1'b0, 2'b01);
        Branch_Taken = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
        check("cnt5", Fetch_Count, 16'h0005);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
